hash_word_serializer: RTL and testbench



---
 rtl/hash_word_serializer.sv | 154 +++++++++++++++
 tb/tb_hash_word_serializer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_word_serializer.sv
// Serializes one captured 256-bit hash into four 64-bit hash-FIFO writes (MSW first)
// and pushes the matching nonce alongside the last word; throttles on FIFO-full.
module hash_word_serializer #(
  parameter int HASH_W  = 256,
  parameter int WORD_W  = 64,
  parameter int NONCE_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [HASH_W-1:0]  hash_in,
  input  logic [NONCE_W-1:0] nonce_in,
  input  logic               hash_valid,
  output logic               hash_ready,
  output logic [WORD_W-1:0]  hash_fifo_din,
  output logic               hash_fifo_we,
  input  logic               hash_fifo_full,
  output logic [NONCE_W-1:0] nonce_fifo_din,
  output logic               nonce_fifo_we,
  input  logic               nonce_fifo_full,
  output logic               busy,
  output logic [31:0]        hash_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HASH = 2'd1,
    SEND      = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [HASH_W-1:0]  hash_q, hash_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [31:0]        count_q, count_d;

  // Word 0 is the most significant lane of the captured hash.
  function automatic logic [WORD_W-1:0] lane_sel(input logic [HASH_W-1:0] h,
                                                 input logic [1:0] i);
    case (i)
      2'd0:    lane_sel = h[4*WORD_W-1 -: WORD_W];
      2'd1:    lane_sel = h[3*WORD_W-1 -: WORD_W];
      2'd2:    lane_sel = h[2*WORD_W-1 -: WORD_W];
      2'd3:    lane_sel = h[WORD_W-1:0];
      default: lane_sel = h[WORD_W-1:0];
    endcase
  endfunction

  // State, index, capture and frame-count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      hash_q  <= {HASH_W{1'b0}};
      nonce_q <= {NONCE_W{1'b0}};
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hash_q  <= hash_d;
      nonce_q <= nonce_d;
      count_q <= count_d;
    end
  end

  // Next-state: stop overrides everything and abandons any partial frame.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hash_d  = hash_q;
    nonce_d = nonce_q;
    count_d = count_q;
    if (stop) begin
      state_d = IDLE;
      idx_d   = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = WAIT_HASH;
            count_d = 32'd0;
          end else begin
            state_d = IDLE;
          end
        end
        WAIT_HASH: begin
          if (hash_valid) begin
            hash_d  = hash_in;
            nonce_d = nonce_in;
            idx_d   = 2'd0;
            state_d = SEND;
          end else begin
            state_d = WAIT_HASH;
          end
        end
        SEND: begin
          if (hash_fifo_we) begin
            if (idx_q == 2'd3) begin
              idx_d   = 2'd0;
              count_d = count_q + 32'd1;
              state_d = WAIT_HASH;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end else begin
            state_d = SEND;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = 2'd0;
        end
      endcase
    end
  end

  // Outputs: the last word is only written when both FIFOs can take it together.
  always_comb begin
    hash_ready     = 1'b0;
    hash_fifo_we   = 1'b0;
    nonce_fifo_we  = 1'b0;
    busy           = 1'b0;
    hash_fifo_din  = {WORD_W{1'b0}};
    nonce_fifo_din = {NONCE_W{1'b0}};
    case (state_q)
      WAIT_HASH: begin
        hash_ready = !stop;
      end
      SEND: begin
        busy          = 1'b1;
        hash_fifo_din = lane_sel(hash_q, idx_q);
        if (idx_q == 2'd3) begin
          nonce_fifo_din = nonce_q;
          if (!stop && !hash_fifo_full && !nonce_fifo_full) begin
            hash_fifo_we  = 1'b1;
            nonce_fifo_we = 1'b1;
          end else begin
            hash_fifo_we  = 1'b0;
            nonce_fifo_we = 1'b0;
          end
        end else begin
          hash_fifo_we = !stop && !hash_fifo_full;
        end
      end
      default: begin
        hash_ready = 1'b0;
      end
    endcase
  end

  assign hash_count = count_q;

endmodule

// File: tb/tb_hash_word_serializer.sv
// Bench for hash_word_serializer: directed vector table, hand-written corner sequences,
// then randomized traffic checked against a queue-based reference model.
module tb_hash_word_serializer;

  logic         clk = 1'b0;
  logic         rst, start, stop, hash_valid, hash_ready;
  logic [255:0] hash_in;
  logic [63:0]  nonce_in, hash_fifo_din, nonce_fifo_din;
  logic         hash_fifo_we, hash_fifo_full, nonce_fifo_we, nonce_fifo_full, busy;
  logic [31:0]  hash_count;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [63:0]  L1 = 64'h1111111111111111;
  localparam logic [63:0]  L2 = 64'h2222222222222222;
  localparam logic [63:0]  L3 = 64'h3333333333333333;
  localparam logic [63:0]  L4 = 64'h4444444444444444;
  localparam logic [63:0]  N1 = 64'hDEADBEEF00000001;
  localparam logic [63:0]  Z  = 64'd0;
  localparam logic [255:0] H1 = {L1, L2, L3, L4};
  localparam logic [63:0]  M1 = 64'hA5A5A5A5A5A5A5A5;
  localparam logic [63:0]  M2 = 64'h0123456789ABCDEF;
  localparam logic [63:0]  M3 = 64'hFEDCBA9876543210;
  localparam logic [63:0]  M4 = 64'h5A5A5A5A5A5A5A5A;
  localparam logic [255:0] H2 = {M1, M2, M3, M4};
  localparam logic [63:0]  N2 = 64'hCAFEF00D12345678;

  hash_word_serializer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .hash_in(hash_in), .nonce_in(nonce_in), .hash_valid(hash_valid),
    .hash_ready(hash_ready), .hash_fifo_din(hash_fifo_din), .hash_fifo_we(hash_fifo_we),
    .hash_fifo_full(hash_fifo_full), .nonce_fifo_din(nonce_fifo_din),
    .nonce_fifo_we(nonce_fifo_we), .nonce_fifo_full(nonce_fifo_full),
    .busy(busy), .hash_count(hash_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, sp, va, hf, nf;
    logic        rdy, hwe, nwe, bz;
    logic [63:0] hdin, ndin;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, input logic sp, input logic va,
                              input logic hf, input logic nf, input logic rdy,
                              input logic hwe, input logic nwe, input logic bz,
                              input logic [63:0] hdin, input logic [63:0] ndin,
                              input logic [31:0] cnt);
    vec_t v;
    v.st = st; v.sp = sp; v.va = va; v.hf = hf; v.nf = nf;
    v.rdy = rdy; v.hwe = hwe; v.nwe = nwe; v.bz = bz;
    v.hdin = hdin; v.ndin = ndin; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %b expected %b", nm, act, exp);
    else n_pass++;
  endtask

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_in();
    start = 1'b0; stop = 1'b0; hash_valid = 1'b0;
    hash_fifo_full = 1'b0; nonce_fifo_full = 1'b0;
  endtask

  // Reference model state for the randomized phase.
  logic [63:0] pend[$];
  logic [63:0] m_nonce;
  logic [31:0] m_cnt;
  bit          m_armed;

  initial begin
    rst = 1'b1;
    idle_in();
    hash_in  = H1;
    nonce_in = N1;
    tick(); tick();
    settle();
    chk1("reset ready", hash_ready, 1'b0);
    chk1("reset hwe", hash_fifo_we, 1'b0);
    chk1("reset nwe", nonce_fifo_we, 1'b0);
    chk1("reset busy", busy, 1'b0);
    chk64("reset hdin", hash_fifo_din, Z);
    chk64("reset ndin", nonce_fifo_din, Z);
    chk64("reset count", {32'd0, hash_count}, Z);
    rst = 1'b0;

    // Basic frame, hash-FIFO stall at word 1, nonce-FIFO stall at word 3.
    //             st   sp   va   hf   nf   rdy  hwe  nwe  bz    hdin ndin cnt
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, Z,  Z,  32'd0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, Z,  Z,  32'd0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1, L1, Z,  32'd0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1, L2, Z,  32'd0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1, L3, Z,  32'd0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b1, L4, N1, 32'd0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, Z,  Z,  32'd1));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, Z,  Z,  32'd1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1, L1, Z,  32'd1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b1, L2, Z,  32'd1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b1, L2, Z,  32'd1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b1, L2, Z,  32'd1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1, L2, Z,  32'd1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1, L3, Z,  32'd1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b1, L4, N1, 32'd1));
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, Z,  Z,  32'd2));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1, L1, Z,  32'd2));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1, L2, Z,  32'd2));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1, L3, Z,  32'd2));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b1, L4, N1, 32'd2));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b1, L4, N1, 32'd2));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b1, L4, N1, 32'd2));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, Z,  Z,  32'd3));

    for (int r = 0; r < tbl.size(); r++) begin
      start = tbl[r].st; stop = tbl[r].sp; hash_valid = tbl[r].va;
      hash_fifo_full = tbl[r].hf; nonce_fifo_full = tbl[r].nf;
      settle();
      chk1($sformatf("row%0d ready", r), hash_ready, tbl[r].rdy);
      chk1($sformatf("row%0d hwe", r), hash_fifo_we, tbl[r].hwe);
      chk1($sformatf("row%0d nwe", r), nonce_fifo_we, tbl[r].nwe);
      chk1($sformatf("row%0d busy", r), busy, tbl[r].bz);
      chk64($sformatf("row%0d hdin", r), hash_fifo_din, tbl[r].hdin);
      chk64($sformatf("row%0d ndin", r), nonce_fifo_din, tbl[r].ndin);
      chk64($sformatf("row%0d count", r), {32'd0, hash_count}, {32'd0, tbl[r].cnt});
      tick();
    end
    idle_in();

    // Stop after two words: no writes, disarmed, count held; restart clears count.
    hash_in = H2; nonce_in = N2;
    hash_valid = 1'b1; settle(); chk1("stop capture ready", hash_ready, 1'b1); tick();
    hash_valid = 1'b0; settle(); chk64("stop w0", hash_fifo_din, M1); chk1("stop w0 we", hash_fifo_we, 1'b1); tick();
    settle(); chk64("stop w1", hash_fifo_din, M2); chk1("stop w1 we", hash_fifo_we, 1'b1); tick();
    stop = 1'b1; settle();
    chk1("stop cycle hwe", hash_fifo_we, 1'b0);
    chk1("stop cycle nwe", nonce_fifo_we, 1'b0);
    chk1("stop cycle ready", hash_ready, 1'b0);
    tick();
    stop = 1'b0; settle();
    chk1("after stop ready", hash_ready, 1'b0);
    chk1("after stop busy", busy, 1'b0);
    chk1("after stop hwe", hash_fifo_we, 1'b0);
    chk64("after stop count", {32'd0, hash_count}, 64'd3);
    tick();
    start = 1'b1; settle(); chk64("restart count before", {32'd0, hash_count}, 64'd3); tick();
    start = 1'b0; hash_valid = 1'b1; settle();
    chk64("restart count cleared", {32'd0, hash_count}, 64'd0);
    chk1("restart ready", hash_ready, 1'b1);
    tick();
    hash_valid = 1'b0; settle();
    chk1("restart w0 we", hash_fifo_we, 1'b1);
    chk64("restart w0", hash_fifo_din, M1);
    tick(); tick(); tick();

    // Ten back-to-back hashes with hash_valid held high.
    stop = 1'b1; tick(); stop = 1'b0; start = 1'b1; tick(); start = 1'b0;
    hash_in = H1; nonce_in = N1;
    begin
      int caps = 0, hw = 0, nw = 0, bad_gap = 0, last_n = -1, cyc = 0;
      while (nw < 10 && cyc < 200) begin
        hash_valid = (caps < 10);
        settle();
        if (hash_ready && hash_valid) caps++;
        if (hash_fifo_we) hw++;
        if (nonce_fifo_we) begin
          if (last_n >= 0 && cyc - last_n != 5) bad_gap++;
          last_n = cyc;
          nw++;
        end
        tick();
        cyc++;
      end
      hash_valid = 1'b0;
      settle();
      chk64("b2b hash writes", 64'(hw), 64'd40);
      chk64("b2b nonce writes", 64'(nw), 64'd10);
      chk64("b2b bad periods", 64'(bad_gap), 64'd0);
      chk64("b2b count", {32'd0, hash_count}, 64'd10);
    end
    tick();

    // Count wrap from 0xFFFFFFFF, then synchronous reset mid-frame.
    force dut.count_q = 32'hFFFFFFFF;
    settle();
    release dut.count_q;
    settle();
    chk64("preload count", {32'd0, hash_count}, 64'h00000000FFFFFFFF);
    tick();
    hash_valid = 1'b1; tick();
    hash_valid = 1'b0; tick(); tick(); tick(); tick();
    settle();
    chk64("wrap count", {32'd0, hash_count}, 64'd0);
    chk1("wrap ready", hash_ready, 1'b1);
    tick();
    hash_valid = 1'b1; tick();
    hash_valid = 1'b0; tick();
    settle(); chk1("mid-frame busy", busy, 1'b1);
    rst = 1'b1; tick(); settle();
    chk1("rst mid ready", hash_ready, 1'b0);
    chk1("rst mid hwe", hash_fifo_we, 1'b0);
    chk1("rst mid nwe", nonce_fifo_we, 1'b0);
    chk1("rst mid busy", busy, 1'b0);
    chk64("rst mid hdin", hash_fifo_din, Z);
    chk64("rst mid ndin", nonce_fifo_din, Z);
    rst = 1'b0;
    tick(); settle();
    chk1("post rst hwe", hash_fifo_we, 1'b0);
    chk1("post rst busy", busy, 1'b0);
    tick();

    // Randomized traffic against a queue-of-pending-words model.
    rst = 1'b1; tick(); rst = 1'b0;
    pend.delete(); m_armed = 1'b0; m_cnt = 32'd0; m_nonce = 64'd0;
    for (int c = 0; c < 3000; c++) begin
      bit m_wait, e_rdy, e_bz, e_hwe, e_nwe;
      start          = ($urandom_range(0, 19) == 0);
      stop           = ($urandom_range(0, 59) == 0);
      hash_valid     = ($urandom_range(0, 1) == 1);
      hash_fifo_full = ($urandom_range(0, 2) == 0);
      nonce_fifo_full = ($urandom_range(0, 3) == 0);
      hash_in  = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
      nonce_in = {$urandom(), $urandom()};
      m_wait = m_armed && (pend.size() == 0);
      e_rdy  = m_wait && !stop;
      e_bz   = (pend.size() != 0);
      e_hwe  = e_bz && !stop && !hash_fifo_full && (pend.size() > 1 || !nonce_fifo_full);
      e_nwe  = e_hwe && (pend.size() == 1);
      settle();
      chk1($sformatf("rnd%0d ready", c), hash_ready, e_rdy);
      chk1($sformatf("rnd%0d busy", c), busy, e_bz);
      chk1($sformatf("rnd%0d hwe", c), hash_fifo_we, e_hwe);
      chk1($sformatf("rnd%0d nwe", c), nonce_fifo_we, e_nwe);
      chk64($sformatf("rnd%0d count", c), {32'd0, hash_count}, {32'd0, m_cnt});
      if (e_hwe) chk64($sformatf("rnd%0d hdin", c), hash_fifo_din, pend[0]);
      if (e_nwe) chk64($sformatf("rnd%0d ndin", c), nonce_fifo_din, m_nonce);
      if (stop) begin
        m_armed = 1'b0;
        pend.delete();
      end else if (!m_armed) begin
        if (start) begin
          m_armed = 1'b1;
          m_cnt = 32'd0;
        end
      end else if (m_wait) begin
        if (hash_valid) begin
          pend.push_back(hash_in[255:192]);
          pend.push_back(hash_in[191:128]);
          pend.push_back(hash_in[127:64]);
          pend.push_back(hash_in[63:0]);
          m_nonce = nonce_in;
        end
      end else if (e_hwe) begin
        void'(pend.pop_front());
        if (e_nwe) m_cnt = m_cnt + 32'd1;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
